// File: rtl/dw_data_sync_na_rx_fifo.sv
// Destination-side receiver for the non-acknowledged data synchronizer.
// Buffers each data_avail_d word in a show-ahead FIFO and counts words lost to overflow.
module dw_data_sync_na_rx_fifo #(
    parameter int width     = 8,
    parameter int depth     = 4,
    parameter int cnt_width = 8
) (
    input  logic                       clk_d,
    input  logic                       rst_d_n,
    input  logic                       init_d_n,
    input  logic                       data_avail_d,
    input  logic [width-1:0]           data_d,
    input  logic                       rd_ready,
    input  logic                       clr_ovf,
    output logic                       rd_valid,
    output logic [width-1:0]           rd_data,
    output logic [$clog2(depth):0]     level,
    output logic                       full,
    output logic                       ovf_flag,
    output logic [cnt_width-1:0]       drop_cnt
);

    localparam int AW    = $clog2(depth);
    localparam int LVL_W = AW + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(depth);

    logic [width-1:0]     mem_q [depth];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 ovf_q, ovf_d;
    logic [cnt_width-1:0] cnt_q, cnt_d;
    logic                 push, pop, drop;

    assign rd_valid = (level_q != '0);
    assign full     = (level_q == DEPTH_L);
    assign level    = level_q;
    assign ovf_flag = ovf_q;
    assign drop_cnt = cnt_q;
    // Mask the head while empty so the output is deterministic after reset/clear.
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;

    assign pop  = rd_valid & rd_ready;
    assign push = data_avail_d & (~full | pop);
    assign drop = data_avail_d & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;
        // A drop coinciding with clr_ovf restarts the count at one.
        if (drop) begin
            ovf_d = 1'b1;
            if (clr_ovf)          cnt_d = cnt_width'(1);
            else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
            cnt_d = '0;
        end
        if (!init_d_n) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_d or negedge rst_d_n) begin
        if (!rst_d_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy tracking alone decides what is valid.
    always_ff @(posedge clk_d) begin
        if (push && init_d_n) mem_q[wr_ptr_q] <= data_d;
    end

endmodule
